// File: rtl/seed_sequencer.sv
// Seeds a ChaCha20 core from a TRNG: gathers key and nonce words, then issues
// one core block per counter value until the block budget or the counter runs out.
module seed_sequencer #(
    parameter int unsigned MAX_BLKS_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic [MAX_BLKS_W-1:0] num_blocks,
    input  logic [31:0]           ctr_init,
    input  logic                  abort,
    output logic                  trng_request,
    input  logic                  trng_ready,
    input  logic [31:0]           trng_data,
    output logic                  core_start,
    output logic [511:0]          core_state,
    input  logic                  core_done,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic                  ctr_ovf
);

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned KEY_WORDS   = 8;
    localparam int unsigned NONCE_WORDS = 3;
    localparam int unsigned FILL_WORDS  = KEY_WORDS + NONCE_WORDS;
    localparam int unsigned IDX_W       = 4;
    localparam logic [4*WORD_W-1:0] SIGMA = 128'h6b206574_79622d32_3320646e_61707865;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t                               state;
    state_t                               next_state;
    logic [IDX_W-1:0]                     idx;
    logic [MAX_BLKS_W-1:0]                blks_rem;
    logic [WORD_W-1:0]                    ctr;
    logic [KEY_WORDS-1:0][WORD_W-1:0]     key;
    logic [NONCE_WORDS-1:0][WORD_W-1:0]   nonce;

    logic load_c;
    logic capture_c;
    logic blk_done_c;
    logic ctr_inc_c;
    logic ovf_set_c;
    logic wipe_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath strobes; abort outranks trng_ready and core_done
    always_comb begin
        next_state = state;
        load_c     = 1'b0;
        capture_c  = 1'b0;
        blk_done_c = 1'b0;
        ctr_inc_c  = 1'b0;
        ovf_set_c  = 1'b0;
        case (state)
            IDLE: begin
                if (load_req) begin
                    if (num_blocks != '0) begin
                        load_c     = 1'b1;
                        next_state = FILL;
                    end else begin
                        next_state = FINISH;
                    end
                end
            end
            FILL: begin
                if (abort) begin
                    next_state = FINISH;
                end else if (trng_ready) begin
                    capture_c = 1'b1;
                    if (idx == IDX_W'(FILL_WORDS - 1)) begin
                        next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                next_state = abort ? FINISH : WAIT;
            end
            WAIT: begin
                if (abort) begin
                    next_state = FINISH;
                end else if (core_done) begin
                    blk_done_c = 1'b1;
                    if (blks_rem == MAX_BLKS_W'(1)) begin
                        next_state = FINISH;
                    end else if (ctr == '1) begin
                        ovf_set_c  = 1'b1;
                        next_state = FINISH;
                    end else begin
                        ctr_inc_c  = 1'b1;
                        next_state = ISSUE;
                    end
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        wipe_c = (next_state == FINISH);
    end

    // Run bookkeeping: word index, blocks remaining, block counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            blks_rem <= '0;
            ctr      <= '0;
        end else begin
            if (load_c) begin
                idx <= '0;
            end else if (capture_c) begin
                idx <= idx + IDX_W'(1);
            end
            if (load_c) begin
                blks_rem <= num_blocks;
            end else if (blk_done_c) begin
                blks_rem <= blks_rem - MAX_BLKS_W'(1);
            end
            if (load_c) begin
                ctr <= ctr_init;
            end else if (ctr_inc_c) begin
                ctr <= ctr + WORD_W'(1);
            end
        end
    end

    // Key/nonce capture in arrival order; wiped whenever a run ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key   <= '0;
            nonce <= '0;
        end else if (wipe_c) begin
            key   <= '0;
            nonce <= '0;
        end else if (capture_c) begin
            for (int unsigned i = 0; i < KEY_WORDS; i++) begin
                if (idx == IDX_W'(i)) begin
                    key[i] <= trng_data;
                end
            end
            for (int unsigned i = 0; i < NONCE_WORDS; i++) begin
                if (idx == IDX_W'(KEY_WORDS + i)) begin
                    nonce[i] <= trng_data;
                end
            end
        end
    end

    // Status and handshake outputs decoded from the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trng_request <= 1'b0;
            core_start   <= 1'b0;
            seq_busy     <= 1'b0;
            seq_done     <= 1'b0;
            ctr_ovf      <= 1'b0;
        end else begin
            trng_request <= (next_state == FILL);
            core_start   <= (next_state == ISSUE);
            seq_busy     <= (next_state != IDLE);
            seq_done     <= (next_state == FINISH);
            if (load_c) begin
                ctr_ovf <= 1'b0;
            end else if (ovf_set_c) begin
                ctr_ovf <= 1'b1;
            end
        end
    end

    assign core_state = {nonce, ctr, key, SIGMA};

endmodule

// File: tb/tb_seed_sequencer.sv
// Bench for seed_sequencer: a run-level model checked every cycle, directed
// scenarios with literal expectations, then a randomized soak.
module tb_seed_sequencer;

    localparam int P_IDLE   = 0;
    localparam int P_FILL   = 1;
    localparam int P_ISSUE  = 2;
    localparam int P_WAIT   = 3;
    localparam int P_FINISH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_req;
    logic [15:0]  num_blocks;
    logic [31:0]  ctr_init;
    logic         abort;
    logic         trng_request;
    logic         trng_ready;
    logic [31:0]  trng_data;
    logic         core_start;
    logic [511:0] core_state;
    logic         core_done;
    logic         seq_busy;
    logic         seq_done;
    logic         ctr_ovf;

    seed_sequencer #(.MAX_BLKS_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_req     (load_req),
        .num_blocks   (num_blocks),
        .ctr_init     (ctr_init),
        .abort        (abort),
        .trng_request (trng_request),
        .trng_ready   (trng_ready),
        .trng_data    (trng_data),
        .core_start   (core_start),
        .core_state   (core_state),
        .core_done    (core_done),
        .seq_busy     (seq_busy),
        .seq_done     (seq_done),
        .ctr_ovf      (ctr_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: run phase, captured words, remaining blocks
    int          m_ph;
    int          m_idx;
    int          m_left;
    bit          m_ovf;
    logic [31:0] m_w [16];

    // Observation logs
    logic [31:0]  cap_log [$];
    logic [31:0]  start_ctr [$];
    int           start_cyc [$];
    logic [511:0] snap;
    int           cap_at_first_start;
    int           done_cnt, busy_cnt, req_cnt, done_cyc, first_req_cyc;
    bit           prev_req;

    int           ready_mode, done_mode, stall_cnt;
    logic [31:0]  data_base;

    task automatic model_reset();
        m_ph   = P_IDLE;
        m_idx  = 0;
        m_left = 0;
        m_ovf  = 1'b0;
        for (int i = 0; i < 16; i++) m_w[i] = 32'h0;
        m_w[0] = 32'h61707865;
        m_w[1] = 32'h3320646e;
        m_w[2] = 32'h79622d32;
        m_w[3] = 32'h6b206574;
    endtask

    task automatic model_finish();
        for (int i = 4; i < 16; i++) if (i != 12) m_w[i] = 32'h0;
        m_ph = P_FINISH;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        case (m_ph)
            P_IDLE: if (load_req) begin
                if (num_blocks != 16'd0) begin
                    m_left = int'(num_blocks);
                    m_w[12] = ctr_init;
                    m_ovf = 1'b0;
                    m_idx = 0;
                    m_ph = P_FILL;
                end else begin
                    model_finish();
                end
            end
            P_FILL: if (abort) model_finish();
                    else if (trng_ready) begin
                        m_w[(m_idx < 8) ? 4 + m_idx : 5 + m_idx] = trng_data;
                        m_idx++;
                        if (m_idx == 11) m_ph = P_ISSUE;
                    end
            P_ISSUE: if (abort) model_finish(); else m_ph = P_WAIT;
            P_WAIT: if (abort) model_finish();
                    else if (core_done) begin
                        m_left--;
                        if (m_left == 0) model_finish();
                        else if (m_w[12] == 32'hFFFFFFFF) begin
                            m_ovf = 1'b1;
                            model_finish();
                        end else begin
                            m_w[12] = m_w[12] + 32'd1;
                            m_ph = P_ISSUE;
                        end
                    end
            default: m_ph = P_IDLE;
        endcase
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare();
        logic [511:0] exp_state;
        for (int i = 0; i < 16; i++) exp_state[i*32 +: 32] = m_w[i];
        chk("flags{req,start,busy,done,ovf}",
            {59'd0, trng_request, core_start, seq_busy, seq_done, ctr_ovf},
            {59'd0, m_ph == P_FILL, m_ph == P_ISSUE, m_ph != P_IDLE, m_ph == P_FINISH, m_ovf});
        total++;
        if (core_state !== exp_state) begin
            bad++;
            $display("FAIL core_state: got %h expected %h", core_state, exp_state);
        end
    endtask

    task automatic clear_logs();
        cap_log.delete();
        start_ctr.delete();
        start_cyc.delete();
        snap = '0;
        cap_at_first_start = -1;
        done_cnt = 0; busy_cnt = 0; req_cnt = 0;
        done_cyc = -1; first_req_cyc = -1;
    endtask

    // One clock: advance the model, compare, then log observations
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        compare();
        if (!rst && prev_req && trng_ready && !abort) cap_log.push_back(trng_data);
        if (core_start) begin
            if (start_ctr.size() == 0) begin
                snap = core_state;
                cap_at_first_start = cap_log.size();
            end
            start_ctr.push_back(core_state[384 +: 32]);
            start_cyc.push_back(cyc);
        end
        if (seq_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (seq_busy) busy_cnt++;
        if (trng_request) begin
            req_cnt++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        prev_req = trng_request;
    endtask

    task automatic drive();
        load_req = 1'b0;
        abort    = 1'b0;
        case (ready_mode)
            0: trng_ready = 1'b1;
            1: begin
                stall_cnt  = (stall_cnt >= 4) ? 0 : stall_cnt + 1;
                trng_ready = (stall_cnt == 4);
            end
            default: trng_ready = 1'($urandom_range(0, 1));
        endcase
        trng_data = trng_ready ? data_base + 32'(cap_log.size()) : $urandom();
        case (done_mode)
            0: core_done = (m_ph == P_WAIT);
            1: core_done = 1'($urandom_range(0, 1));
            default: core_done = 1'b0;
        endcase
    endtask

    task automatic start_run(input int nb, input logic [31:0] ci, output int e);
        drive();
        load_req   = 1'b1;
        num_blocks = 16'(nb);
        ctr_init   = ci;
        cycle();
        e = cyc;
        load_req = 1'b0;
    endtask

    task automatic run_until_done(input string name, input int limit);
        int d0 = done_cnt;
        for (int i = 0; i < limit; i++) begin
            drive();
            cycle();
            if (done_cnt != d0) break;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL %s: no seq_done within %0d cycles", name, limit);
        end
        drive();
        cycle();
    endtask

    task automatic chk_wiped(input string name);
        for (int i = 4; i < 16; i++)
            if (i != 12) chk(name, 64'(core_state[i*32 +: 32]), 64'd0);
    endtask

    initial begin
        int e;
        logic [31:0] ci;
        rst = 1'b0; load_req = 1'b0; num_blocks = '0; ctr_init = '0; abort = 1'b0;
        trng_ready = 1'b0; trng_data = '0; core_done = 1'b0;
        ready_mode = 0; done_mode = 0; stall_cnt = 0; data_base = 32'd1; prev_req = 1'b0;
        clear_logs();
        #1 rst = 1'b1;
        #1;
        model_reset();
        compare();
        chk("reset_flags", {59'd0, trng_request, core_start, seq_busy, seq_done, ctr_ovf}, 64'd0);
        chk("reset_w0", 64'(core_state[31:0]), 64'h61707865);
        chk("reset_w3", 64'(core_state[127:96]), 64'h6b206574);
        chk_wiped("reset_key");
        chk("reset_ctr", 64'(core_state[384 +: 32]), 64'd0);
        repeat (2) begin drive(); cycle(); end
        rst = 1'b0;
        drive(); cycle();

        // Nominal run: three blocks from counter 5
        clear_logs(); ready_mode = 0; done_mode = 0; data_base = 32'd1;
        start_run(3, 32'd5, e);
        run_until_done("nominal", 200);
        chk("nom_first_req", 64'(first_req_cyc), 64'(e));
        chk("nom_req_cycles", 64'(req_cnt), 64'd11);
        chk("nom_starts", 64'(start_ctr.size()), 64'd3);
        if (start_cyc.size() > 0) chk("nom_latency", 64'(start_cyc[0]), 64'(e + 11));
        for (int i = 0; i < start_ctr.size() && i < 3; i++)
            chk("nom_ctr", 64'(start_ctr[i]), 64'(5 + i));
        for (int i = 0; i < 8; i++) chk("nom_key", 64'(snap[(4 + i)*32 +: 32]), 64'(i + 1));
        for (int i = 0; i < 3; i++) chk("nom_nonce", 64'(snap[(13 + i)*32 +: 32]), 64'(9 + i));
        chk("nom_done_cnt", 64'(done_cnt), 64'd1);
        chk("nom_ovf", 64'(ctr_ovf), 64'd0);
        chk_wiped("nom_wiped");

        // TRNG stall: four idle cycles between words
        clear_logs(); ready_mode = 1; stall_cnt = 0; data_base = 32'hA000_0000;
        start_run(1, $urandom(), e);
        run_until_done("stall", 500);
        chk("stall_caps", 64'(cap_log.size()), 64'd11);
        chk("stall_caps_at_start", 64'(cap_at_first_start), 64'd11);
        for (int i = 0; i < 11; i++)
            chk("stall_word", 64'(snap[((i < 8) ? 4 + i : 5 + i)*32 +: 32]), 64'(32'hA000_0000 + 32'(i)));
        chk("stall_starts", 64'(start_ctr.size()), 64'd1);

        // Counter boundary: no wrap past 0xFFFFFFFF
        clear_logs(); ready_mode = 0; data_base = 32'h33;
        start_run(4, 32'hFFFF_FFFE, e);
        run_until_done("ovf", 200);
        chk("ovf_starts", 64'(start_ctr.size()), 64'd2);
        for (int i = 0; i < start_ctr.size() && i < 2; i++)
            chk("ovf_ctr", 64'(start_ctr[i]), 64'(32'hFFFF_FFFE + 32'(i)));
        chk("ovf_flag", 64'(ctr_ovf), 64'd1);
        chk("ovf_done_cnt", 64'(done_cnt), 64'd1);

        // Zero-length run
        clear_logs();
        start_run(0, 32'd9, e);
        repeat (3) begin drive(); cycle(); end
        chk("zero_done_cyc", 64'(done_cyc), 64'(e));
        chk("zero_done_cnt", 64'(done_cnt), 64'd1);
        chk("zero_req_cnt", 64'(req_cnt), 64'd0);
        chk("zero_busy_cnt", 64'(busy_cnt), 64'd1);
        chk("zero_ovf_sticky", 64'(ctr_ovf), 64'd1);

        // Abort coincident with core_done
        clear_logs(); done_mode = 2;
        start_run(3, 32'h100, e);
        for (int i = 0; i < 50 && m_ph != P_WAIT; i++) begin drive(); cycle(); end
        chk("abort_reached_wait", 64'(m_ph == P_WAIT), 64'd1);
        drive(); abort = 1'b1; core_done = 1'b1;
        cycle();
        repeat (4) begin drive(); cycle(); end
        chk("abort_starts", 64'(start_ctr.size()), 64'd1);
        chk("abort_done_cnt", 64'(done_cnt), 64'd1);
        chk("abort_idle", 64'(seq_busy), 64'd0);

        // Second load_req while busy is dropped
        clear_logs(); done_mode = 0;
        start_run(2, 32'h10, e);
        for (int i = 0; i < 50 && cap_log.size() < 3; i++) begin drive(); cycle(); end
        drive(); load_req = 1'b1; num_blocks = 16'd5; ctr_init = 32'h99;
        cycle();
        run_until_done("reload", 200);
        chk("reload_starts", 64'(start_ctr.size()), 64'd2);
        for (int i = 0; i < start_ctr.size() && i < 2; i++)
            chk("reload_ctr", 64'(start_ctr[i]), 64'(32'h10 + 32'(i)));

        // Reset mid-FILL after five words, then restart
        clear_logs(); data_base = 32'h500;
        start_run(1, 32'd7, e);
        for (int i = 0; i < 50 && cap_log.size() < 5; i++) begin drive(); cycle(); end
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        chk("rst_mid_flags", {59'd0, trng_request, core_start, seq_busy, seq_done, ctr_ovf}, 64'd0);
        chk_wiped("rst_mid_key");
        repeat (2) begin drive(); cycle(); end
        rst = 1'b0;
        drive(); cycle();
        chk("rst_mid_no_done", 64'(done_cnt), 64'd0);
        clear_logs(); data_base = 32'h600;
        start_run(1, 32'd7, e);
        run_until_done("restart", 200);
        chk("restart_w4", 64'(snap[4*32 +: 32]), 64'h600);
        chk("restart_w15", 64'(snap[15*32 +: 32]), 64'h60A);

        // Randomized soak against the model
        ready_mode = 2; done_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            data_base = $urandom();
            drive();
            load_req   = ($urandom_range(0, 7) == 0);
            num_blocks = 16'($urandom_range(0, 3));
            ci = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD + 32'($urandom_range(0, 2)) : $urandom();
            ctr_init   = ci;
            abort      = ($urandom_range(0, 39) == 0);
            rst        = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0;
        repeat (3) begin drive(); cycle(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
